// File: rtl/imem_responder_pkg.sv
// Shared constants, state and fault encodings for the instruction-memory responder.
package imem_responder_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned BYTE_W = 8;
  localparam logic [XLEN-1:0] RV_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH_OK       = 2'b00,
    FETCH_MISALIGN = 2'b01,
    FETCH_RANGE    = 2'b10
  } fetch_fault_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOAD = 1'b1
  } ld_state_e;

  // Classify a base-relative byte offset; wrapped offsets land in FETCH_RANGE.
  function automatic fetch_fault_e fetch_classify(input logic [XLEN-1:0] off,
                                                  input int unsigned depth);
    fetch_fault_e code;
    code = FETCH_OK;
    if (off[1:0] != 2'b00) begin
      code = FETCH_MISALIGN;
    end else if (XLEN'({2'b00, off[XLEN-1:2]}) >= XLEN'(depth)) begin
      code = FETCH_RANGE;
    end
    return code;
  endfunction

endpackage

// File: rtl/imem_ram.sv
// Single-port synchronous word RAM, write-first, with a registered read that can be
// forced to the NOP word for faulted fetches.
module imem_ram
  import imem_responder_pkg::*;
#(
  parameter int unsigned      DEPTH_WORDS = 1024,
  parameter logic [XLEN-1:0]  NOP_WORD    = RV_NOP,
  localparam int unsigned     AW          = $clog2(DEPTH_WORDS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we_i,
  input  logic            re_i,
  input  logic            kill_i,
  input  logic [AW-1:0]   addr_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic [XLEN-1:0] rdata_o
);

  logic [XLEN-1:0] mem [DEPTH_WORDS];
  logic [XLEN-1:0] rdata_q, rdata_d;

  // Storage array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[addr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      if (kill_i) begin
        rdata_d = NOP_WORD;
      end else if (we_i) begin
        rdata_d = wdata_i;
      end else begin
        rdata_d = mem[addr_i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= NOP_WORD;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: serves IF-stage fetches and hosts a byte-serial
// boot loader that fills the RAM while stalling the pipeline via busy_o.
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int unsigned     DEPTH_WORDS = 1024,
  parameter logic [XLEN-1:0] ADDR_BASE   = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSN    = RV_NOP,
  localparam int unsigned    AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              imem_req_i,
  input  logic [XLEN-1:0]   imem_addr_i,
  output logic [XLEN-1:0]   imem_data_o,
  output logic              imem_valid_o,
  output logic              imem_fault_o,
  output logic              busy_o,
  input  logic              ld_start_i,
  input  logic [AW:0]       ld_len_i,
  input  logic [BYTE_W-1:0] ld_byte_i,
  input  logic              ld_valid_i,
  output logic              ld_err_o
);

  ld_state_e       state_q, state_d;
  logic [1:0]      byte_cnt_q, byte_cnt_d;
  logic [AW:0]     word_cnt_q, word_cnt_d;
  logic [AW:0]     len_q, len_d;
  logic [XLEN-1:0] asm_q, asm_d;
  logic            valid_q, valid_d;
  logic            fault_q, fault_d;
  logic            busy_q, busy_d;
  logic            err_q, err_d;

  logic            ram_we, ram_re, ram_kill;
  logic [AW-1:0]   ram_addr;
  logic [XLEN-1:0] ram_wdata, ram_rdata;
  logic [XLEN-1:0] off;
  fetch_fault_e    fcode;

  assign off   = imem_addr_i - ADDR_BASE;
  assign fcode = fetch_classify(off, DEPTH_WORDS);

  // Next-state: fetch acceptance in IDLE, byte assembly and word writes in LOAD.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    len_d      = len_q;
    asm_d      = asm_q;
    err_d      = err_q;
    valid_d    = 1'b0;
    fault_d    = 1'b0;
    ram_we     = 1'b0;
    ram_re     = 1'b0;
    ram_kill   = 1'b0;
    ram_addr   = off[AW+1:2];

    case (state_q)
      ST_IDLE: begin
        if (imem_req_i) begin
          ram_re   = 1'b1;
          ram_kill = (fcode != FETCH_OK);
          valid_d  = 1'b1;
          fault_d  = ram_kill;
        end
        if (ld_start_i) begin
          err_d = (XLEN'(ld_len_i) > XLEN'(DEPTH_WORDS));
          if (ld_len_i != '0) begin
            state_d    = ST_LOAD;
            len_d      = err_d ? (AW+1)'(DEPTH_WORDS) : ld_len_i;
            byte_cnt_d = '0;
            word_cnt_d = '0;
            asm_d      = '0;
          end
        end
      end
      ST_LOAD: begin
        if (ld_valid_i) begin
          asm_d[{byte_cnt_q, 3'b000} +: BYTE_W] = ld_byte_i;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            ram_we     = 1'b1;
            ram_addr   = word_cnt_q[AW-1:0];
            word_cnt_d = word_cnt_q + (AW+1)'(1);
            if (word_cnt_d == len_q) begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d    = (state_d == ST_LOAD);
    ram_wdata = asm_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      byte_cnt_q <= '0;
      word_cnt_q <= '0;
      len_q      <= '0;
      asm_q      <= '0;
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      len_q      <= len_d;
      asm_q      <= asm_d;
      valid_q    <= valid_d;
      fault_q    <= fault_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  imem_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .NOP_WORD    (NOP_INSN)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .kill_i  (ram_kill),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  assign imem_data_o  = ram_rdata;
  assign imem_valid_o = valid_q;
  assign imem_fault_o = fault_q;
  assign busy_o       = busy_q;
  assign ld_err_o     = err_q;

endmodule

// File: tb/tb_imem_responder.sv
// Randomized bench for imem_responder against an array-based memory model.
module tb_imem_responder;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned AW    = 6;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        imem_valid, imem_fault, busy, ld_err;
  logic        ld_start, ld_valid;
  logic [AW:0] ld_len;
  logic [7:0]  ld_byte;

  always #5 clk = ~clk;

  imem_responder #(
    .DEPTH_WORDS (DEPTH),
    .ADDR_BASE   (BASE),
    .NOP_INSN    (NOP)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req_i   (imem_req),
    .imem_addr_i  (imem_addr),
    .imem_data_o  (imem_data),
    .imem_valid_o (imem_valid),
    .imem_fault_o (imem_fault),
    .busy_o       (busy),
    .ld_start_i   (ld_start),
    .ld_len_i     (ld_len),
    .ld_byte_i    (ld_byte),
    .ld_valid_i   (ld_valid),
    .ld_err_o     (ld_err)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [31:0] model [DEPTH];
  logic [31:0] wq [$];
  logic [31:0] last_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 5))
      0:       a = BASE + 32'($urandom_range(0, DEPTH - 1) * 4) + 32'($urandom_range(1, 3));
      1:       a = BASE + 32'(DEPTH * 4) + 32'($urandom_range(0, 255) * 4);
      2:       a = $urandom();
      default: a = BASE + 32'($urandom_range(0, DEPTH - 1) * 4);
    endcase
    return a;
  endfunction

  // One fetch; expected response comes purely from the model.
  task automatic fetch(input string tag, input logic [31:0] addr);
    logic [31:0] off;
    logic        flt;
    logic [31:0] exp;
    off = addr - BASE;
    flt = (addr[1:0] != 2'b00) || ((off >> 2) >= 32'(DEPTH));
    exp = flt ? NOP : model[(off >> 2) % DEPTH];
    imem_req  = 1'b1;
    imem_addr = addr;
    step();
    imem_req  = 1'b0;
    check({tag, "_valid"}, 32'(imem_valid), 32'd1);
    check({tag, "_fault"}, 32'(imem_fault), 32'(flt));
    check({tag, "_data"},  imem_data, exp);
    last_data = exp;
  endtask

  task automatic idle_cycle(input string tag);
    imem_req = 1'b0;
    step();
    check({tag, "_valid"}, 32'(imem_valid), 32'd0);
    check({tag, "_hold"},  imem_data, last_data);
  endtask

  // Start a load of len_req words taken from wq, streaming bytes with random gaps
  // while fetch requests are held; model updated once the load is complete.
  task automatic run_load(input int unsigned len_req);
    int unsigned eff, total, sent;
    logic v;
    eff   = (len_req > DEPTH) ? DEPTH : len_req;
    total = eff * 4;
    imem_req = 1'b0;
    ld_start = 1'b1;
    ld_len   = (AW+1)'(len_req);
    step();
    ld_start = 1'b0;
    check("ld_busy_rise", 32'(busy), 32'd1);
    check("ld_err", 32'(ld_err), 32'(len_req > DEPTH));
    sent = 0;
    while (sent < total) begin
      v         = ($urandom_range(0, 3) != 0);
      ld_valid  = v;
      ld_byte   = 8'(wq[sent / 4] >> (8 * (sent % 4)));
      imem_req  = 1'b1;
      imem_addr = rand_addr();
      step();
      if (v) sent++;
      if (!v || sent == total || (sent % 16) == 0) begin
        check("ld_req_ignored", 32'(imem_valid), 32'd0);
        check("ld_busy", 32'(busy), 32'(sent < total));
      end
    end
    ld_valid = 1'b0;
    imem_req = 1'b0;
    for (int i = 0; i < int'(eff); i++) model[i] = wq[i];
  endtask

  initial begin
    rst_n = 1'b0; imem_req = 1'b0; imem_addr = '0;
    ld_start = 1'b0; ld_len = '0; ld_byte = '0; ld_valid = 1'b0;
    last_data = NOP;
    repeat (3) @(negedge clk);
    check("rst_data",  imem_data, NOP);
    check("rst_valid", 32'(imem_valid), 32'd0);
    check("rst_fault", 32'(imem_fault), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_err",   32'(ld_err), 32'd0);
    rst_n = 1'b1;
    step();

    // Directed boot image, then back-to-back fetches.
    wq = '{32'h0050_0093, 32'h0000_0013};
    run_load(2);
    fetch("f0", 32'h0);
    fetch("f4", 32'h4);
    idle_cycle("idle0");
    fetch("mis2", 32'h2);
    fetch("oor", 32'(DEPTH * 4));
    fetch("wrap", 32'hFFFF_FFFC);
    idle_cycle("idle1");

    // Oversized length: clamps to DEPTH words and raises ld_err.
    wq.delete();
    for (int i = 0; i < int'(DEPTH) + 1; i++) wq.push_back($urandom());
    run_load(DEPTH + 1);
    check("err_sticky", 32'(ld_err), 32'd1);
    // Bytes in IDLE are dropped.
    for (int i = 0; i < 8; i++) begin
      ld_valid = 1'b1; ld_byte = 8'($urandom());
      step();
      check("idle_bytes_busy", 32'(busy), 32'd0);
    end
    ld_valid = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) fetch("sweep", BASE + 32'(i * 4));

    // Zero-length start: no load, error cleared.
    ld_start = 1'b1; ld_len = '0;
    step();
    ld_start = 1'b0;
    check("len0_busy", 32'(busy), 32'd0);
    check("len0_err",  32'(ld_err), 32'd0);
    step();
    check("len0_busy2", 32'(busy), 32'd0);

    // Random fetch traffic.
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) idle_cycle("rnd_idle");
      else fetch("rnd", rand_addr());
    end

    // Random-length reload.
    wq.delete();
    for (int i = 0; i < 20; i++) wq.push_back($urandom());
    run_load($urandom_range(1, 20));
    for (int i = 0; i < 40; i++) fetch("reload", rand_addr());

    // Reset in the middle of word 1.
    wq = '{32'hA5A5_1234, 32'hDEAD_BEEF};
    imem_req = 1'b0;
    ld_start = 1'b1; ld_len = (AW+1)'(2);
    step();
    ld_start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      ld_valid = 1'b1;
      ld_byte  = 8'(wq[i / 4] >> (8 * (i % 4)));
      step();
    end
    ld_valid = 1'b0;
    check("mid_busy_pre", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy",  32'(busy), 32'd0);
    check("mid_rst_data",  imem_data, NOP);
    check("mid_rst_valid", 32'(imem_valid), 32'd0);
    check("mid_rst_fault", 32'(imem_fault), 32'd0);
    check("mid_rst_err",   32'(ld_err), 32'd0);
    model[0] = wq[0];
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("post_rst_busy", 32'(busy), 32'd0);
    fetch("post_rst_w0", 32'h0);
    fetch("post_rst_w1", 32'h4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
